// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the bit-counter width rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // The counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full-adder cell used by the serial adder datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes an operand bit per cycle,
// with a valid/ready handshake on both the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .sum(fa_sum),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in sum_sr[0].
  always_comb begin
    a_shift              = a_sr >> 1;
    b_shift              = b_sr >> 1;
    sum_shift            = sum_sr >> 1;
    sum_shift[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_shift;
      b_sr   <= b_shift;
      sum_sr <= sum_shift;
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

endmodule
